// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline types: fetch buffer entries, in-flight fetch tags and
// helpers used by the front end.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Epoch width that keeps stale tags from aliasing for up to 8 requests in flight
  localparam int EPOCH_W = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [EPOCH_W-1:0] epoch;
  } fetch_tag_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32_sync_fifo.sv
// Synchronous FIFO with a generic element type, synchronous flush and a
// show-ahead head read from registered storage.
module rv32_sync_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];

  // A push into a full FIFO is legal when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= next_ptr(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= next_ptr(rd_ptr_reg);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rv32_fetch_unit.sv
// RV32I instruction-fetch front end: PC ownership, credit-limited IMEM requests,
// epoch-tagged wrong-path squashing and an instruction buffer toward IF/ID.
module rv32_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr
);

  localparam int BUF_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int STALE_W   = OUT_W + 4;

  logic [XLEN-1:0]    pc_reg;
  logic [EPOCH_W-1:0] epoch_reg;
  logic [STALE_W-1:0] stale_reg;

  fetch_tag_t         tag_push;
  fetch_tag_t         tag_head;
  logic               tag_full;
  logic               tag_empty;
  logic [OUT_W-1:0]   outstanding;

  fetch_entry_t       buf_push;
  fetch_entry_t       buf_head;
  logic               buf_full;
  logic               buf_empty;
  logic [BUF_CNT_W-1:0] buf_count;

  logic [31:0]        credit_sum;
  logic               credit_ok;
  logic               req_fire;
  logic               rsp_live;
  logic               rsp_keep;
  logic               rsp_retire_in_rst;
  logic               head_fire;

  // Credit uses registered occupancy only, so fetch_ready never reaches the request path
  assign credit_sum     = 32'(outstanding) + 32'(buf_count);
  assign credit_ok      = !tag_full && !buf_full && (credit_sum < 32'(FIFO_DEPTH));
  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = rst ? word_align(RESET_PC) : word_align(pc_reg);
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses owed to requests issued before the last reset are swallowed first
  assign rsp_live = imem_rsp_valid && (stale_reg == '0);
  assign rsp_keep = rsp_live && !tag_empty && (tag_head.epoch == epoch_reg) && !redirect_valid;
  assign rsp_retire_in_rst = imem_rsp_valid && ((stale_reg != '0) || (outstanding != '0));

  assign tag_push = '{pc: pc_reg, epoch: epoch_reg};
  assign buf_push = '{pc: tag_head.pc, instr: imem_rsp_data};

  assign fetch_valid = !rst && !buf_empty;
  assign head_fire   = fetch_valid && fetch_ready;
  assign fetch_pc    = fetch_valid ? buf_head.pc : '0;
  assign fetch_instr = fetch_valid ? buf_head.instr : NOP_INSTR;

  rv32_sync_fifo #(
    .T     (fetch_tag_t),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (tag_push),
    .pop       (rsp_live),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (outstanding)
  );

  rv32_sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (buf_push),
    .pop       (head_fire),
    .pop_data  (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      epoch_reg <= '0;
    end else if (redirect_valid) begin
      pc_reg    <= word_align(redirect_pc);
      epoch_reg <= epoch_reg + EPOCH_W'(1);
    end else if (req_fire) begin
      pc_reg <= pc_reg + 32'd4;
    end
  end

  // On reset every request still in flight becomes a stale response to drop
  always_ff @(posedge clk) begin
    if (rst) begin
      stale_reg <= stale_reg + STALE_W'(outstanding) - STALE_W'(rsp_retire_in_rst);
    end else if (imem_rsp_valid && (stale_reg != '0)) begin
      stale_reg <= stale_reg - STALE_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Scoreboard bench for rv32_fetch_unit: a memory responder with variable
// latency, expected fetch streams derived from reset/redirect targets.
module tb_rv32_fetch_unit;
  import rv32_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          EXP_N    = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;

  always #5 clk = ~clk;

  rv32_fetch_unit #(
    .RESET_PC        (RESET_PC),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memreq_t;

  exp_t    exp_q[$];
  memreq_t mem_q[$];
  int      total = 0;
  int      bad   = 0;
  int      got   = 0;
  int      cyc   = 0;
  int      mem_lat = 1;
  bit      rand_ready = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0010_0093 + {2'b00, a[31:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Program order from a fetch target: target, target+4, ... modulo 2^32
  task automatic start_stream(input logic [31:0] target);
    logic [31:0] p;
    exp_q.delete();
    for (int i = 0; i < EXP_N; i++) begin
      p = {target[31:2], 2'b00} + 32'(4 * i);
      exp_q.push_back('{pc: p, instr: mem_word(p)});
    end
  endtask

  // Instruction memory: in-order, fixed latency per request, never back-pressured
  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready)
        mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      @(posedge clk);
      cyc++;
      #1;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      imem_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: reset values, stall hold, post-redirect bubble, scoreboard pops
  logic        prev_stall;
  logic        prev_redir;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  initial begin
    exp_t e;
    prev_stall = 1'b0;
    prev_redir = 1'b0;
    prev_pc    = '0;
    prev_instr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_fetch_pc", fetch_pc, 32'd0);
        check("rst_fetch_instr", fetch_instr, 32'h0000_0013);
        prev_stall = 1'b0;
        prev_redir = 1'b0;
      end else begin
        if (prev_redir)
          check("valid_after_redirect", 32'(fetch_valid), 32'd0);
        if (prev_stall) begin
          check("stall_valid", 32'(fetch_valid), 32'd1);
          check("stall_pc", fetch_pc, prev_pc);
          check("stall_instr", fetch_instr, prev_instr);
        end
        if (fetch_valid && fetch_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got pc=%h, want no transfer", fetch_pc);
          end else begin
            e = exp_q.pop_front();
            $display("xfer pc=%h instr=%h exp_pc=%h", fetch_pc, fetch_instr, e.pc);
            check("fetch_pc", fetch_pc, e.pc);
            check("fetch_instr", fetch_instr, e.instr);
            got++;
          end
        end
        prev_stall = fetch_valid && !fetch_ready && !redirect_valid;
        prev_redir = redirect_valid;
        prev_pc    = fetch_pc;
        prev_instr = fetch_instr;
      end
    end
  end

  task automatic run_seg(input int cycles, input int min_items, input bit rand_fr, input string name);
    int g0;
    g0 = got;
    for (int c = 0; c < cycles; c++) begin
      fetch_ready = rand_fr ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(posedge clk);
      #1;
    end
    fetch_ready = 1'b1;
    total++;
    if (got - g0 < min_items) begin
      bad++;
      $display("FAIL %s: got %0d transfers, want at least %0d", name, got - g0, min_items);
    end
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    start_stream(RESET_PC);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] target, input bit check_busy);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    start_stream(target);
    @(negedge clk);
    if (check_busy) begin
      check("redir_head_fire", 32'(fetch_valid && fetch_ready), 32'd1);
      check("redir_rsp_valid", 32'(imem_rsp_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  // Waits (bounded) until the memory holds at least `need` accepted requests
  task automatic wait_inflight(input int need, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (mem_q.size() < need && n < 40);
    total++;
    if (mem_q.size() < need) begin
      bad++;
      $display("FAIL %s: got %0d in flight, want %0d", name, mem_q.size(), need);
    end
  endtask

  initial begin
    int first;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fetch_ready    = 1'b1;

    // Reset release and steady stream with 1-cycle memory
    repeat (3) @(posedge clk);
    #1;
    start_stream(RESET_PC);
    rst   = 1'b0;
    first = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (first == 0 && fetch_valid) first = c;
      if (first != 0 && c > first) check("steady_valid", 32'(fetch_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    check("first_valid_cycle", 32'(first), 32'd3);

    // Five-cycle stall: outputs frozen, requests stop at four credits
    fetch_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 5) begin
        check("stall_credit_block", 32'(imem_req_valid), 32'd0);
        check("stall_still_valid", 32'(fetch_valid), 32'd1);
      end
      @(posedge clk);
      #1;
    end
    run_seg(20, 18, 1'b0, "after_stall_progress");

    // 3-cycle memory, redirect to 0x100 with two requests outstanding
    mem_lat = 3;
    pulse_reset(2);
    wait_inflight(2, "inflight_before_redirect");
    do_redirect(32'h0000_0100, 1'b0);
    run_seg(40, 15, 1'b0, "lat3_progress");

    // Redirect to an unaligned target during a head handshake and a response
    mem_lat = 1;
    run_seg(15, 8, 1'b0, "lat1_settle");
    do_redirect(32'h0000_0202, 1'b1);
    run_seg(15, 10, 1'b0, "after_0x202");

    // Wrap past the top of the address space
    do_redirect(32'hFFFF_FFFC, 1'b0);
    run_seg(15, 10, 1'b0, "wrap_progress");

    // Back-to-back redirects: the second target wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    start_stream(32'h0000_0400);
    @(posedge clk);
    #1;
    redirect_pc = 32'h0000_0800;
    start_stream(32'h0000_0800);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    run_seg(15, 10, 1'b0, "b2b_redirect_progress");

    // Randomised ready, latency and redirect targets
    rand_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mem_lat = $urandom_range(1, 4);
      run_seg(40, 3, 1'b1, "random_progress");
      do_redirect($urandom, 1'b0);
    end

    // Reset pulse with requests in flight; stale responses must be dropped
    mem_lat = 3;
    run_seg(10, 1, 1'b1, "pre_reset_progress");
    wait_inflight(1, "inflight_before_reset");
    pulse_reset(2);
    run_seg(60, 5, 1'b1, "post_reset_progress");
    rand_ready = 1'b0;
    run_seg(20, 5, 1'b0, "final_progress");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rv32_fetch_unit.md
Name: rv32_fetch_unit

Overview:
Instruction-fetch front end of the RV32I pipeline. It sits upstream of the IF/ID register, which feeds decode and the hazard/forwarding logic.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions and presents them to IF/ID under a valid/ready handshake. fetch_ready low is the hazard-unit stall, e.g. load-use.
- Accepts branch/jump redirects from EX, flushing all wrong-path instructions, including those still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)
MAX_OUTSTANDING, 2, maximum IMEM requests in flight

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response valid; in request order, >=1 cycle after acceptance, never back-pressured
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  EX-resolved taken branch/jump
redirect_pc  in  32  redirect target
fetch_valid  out  1  fetch_pc/fetch_instr valid to IF/ID
fetch_ready  in  1  IF/ID accepts; low = stall
fetch_pc  out  32  PC of presented instruction
fetch_instr  out  32  presented instruction

Behaviour:
- Reset (rst high at a clk edge):
  - pc_q=RESET_PC, buffer empty, outstanding=0, epoch=0.
  - Outputs while rst is high: imem_req_valid=0, fetch_valid=0, imem_req_addr=RESET_PC, fetch_pc=0, fetch_instr=32'h0000_0013 (NOP).
  - Reset mid-operation discards everything. Responses arriving after reset for pre-reset requests are dropped; outstanding is cleared and in-flight tags are marked stale.
- Credit rule:
  - imem_req_valid = !rst && !redirect_valid && (outstanding < MAX_OUTSTANDING) && (outstanding + count < FIFO_DEPTH).
  - The rule uses registered state only; there is no combinational path from fetch_ready.
- Request handshake (imem_req_valid && imem_req_ready):
  - Push {pc_q, epoch} into the in-flight tag queue.
  - pc_q <= pc_q + 4, wrapping modulo 2^32.
  - outstanding++.
- imem_req_addr = {pc_q[31:2], 2'b00}.
- Response:
  - Pop the tag queue and decrement outstanding.
  - If tag epoch == current epoch and no redirect this cycle: push {tag.pc, imem_rsp_data} into the buffer.
  - Otherwise discard.
  - Simultaneous request and response: outstanding is unchanged.
- Output:
  - fetch_valid = buffer non-empty.
  - fetch_pc/fetch_instr = registered buffer head. There is no response-to-output bypass, so first valid is 1 cycle after the response.
  - With 1-cycle memory, first valid appears 3 cycles after rst falls.
- Stall: while fetch_valid && !fetch_ready, the head and all outputs hold stable. Fetching continues until credits are exhausted.
- Pop occurs on fetch_valid && fetch_ready. Push and pop in the same cycle keep count, including when full with credit 0.
- Redirect (redirect_valid=1 in cycle N):
  - No request in N.
  - Buffer flushed, including any head handshake in N.
  - pc_q <= {redirect_pc[31:2], 2'b00}; epoch toggles.
  - In-flight responses with the old epoch are discarded as they return.
  - First request to the target in N+1, provided credit allows (outstanding is not cleared by redirect).
- Redirect during a stall: the flush wins and fetch_valid=0 in N+1.
- Back-to-back redirects: the last one wins; the epoch toggles each time.
  - The tag epoch must be wide enough that stale tags never alias: 2 bits for MAX_OUTSTANDING=2, generally clog2(MAX_OUTSTANDING)+1.
- Steady state, 1-cycle memory, fetch_ready=1: one instruction per cycle.

Decomposition:
- rv32_pkg (shared): XLEN=32, NOP_INSTR=32'h0000_0013, fetch_entry_t {pc, instr}, fetch_tag_t {pc, epoch}.
- One reusable sub-module, rv32_sync_fifo: parameterised type and depth, synchronous flush, full/empty/count. It is instantiated twice, as the instruction buffer and as the tag queue.
- The fetch_unit holds the PC, epoch, outstanding counter and credit logic.

Test Plan:
1. Reset, then memory word[i]=0x00100093+i with 1-cycle latency and fetch_ready=1 -> fetch_pc 0,4,8,... on consecutive cycles with the matching fetch_instr; first fetch_valid exactly 3 cycles after rst falls.
2. After the stream starts, hold fetch_ready=0 for 5 cycles -> fetch_pc/instr frozen; imem_req_valid drops once outstanding+count reaches 4; no instruction lost or duplicated after release.
3. Memory latency 3 cycles, redirect_pc=0x100 while 2 requests are outstanding -> stale responses for 0x0C/0x10 are never presented; next fetch_pc=0x100, then 0x104.
4. Redirect to 0x00000202 in the same cycle as a head handshake plus a response -> the handshake instruction is dropped; next fetch_pc=0x200.
5. Redirect to 0xFFFFFFFC -> fetch_pc 0xFFFFFFFC then 0x00000000 (wrap).
6. Random imem_req_ready with rst pulsed mid-stream (requests outstanding) -> outputs at reset values during rst; stale responses dropped; stream restarts at RESET_PC.
